// File: rtl/map_table_pkg.sv
// map_table_pkg: shared rename-table types and sizing constants.
package map_table_pkg;
  localparam int REG_LEN  = 5;
  localparam int ZERO_REG = 0;
  localparam int ROB_LEN  = 8;
  typedef logic [$clog2(ROB_LEN)-1:0] rob_tag_t;
  typedef struct packed {
    rob_tag_t tag;
    logic     busy;
    logic     ready;
  } MT_entry_PACKET;
  typedef struct packed {
    logic [REG_LEN-1:0] rs1_idx;
    logic [REG_LEN-1:0] rs2_idx;
  } RS2MT;
  typedef struct packed {
    MT_entry_PACKET rs1;
    MT_entry_PACKET rs2;
  } MT2RS;
  typedef struct packed {
    rob_tag_t head_idx;
    logic     retire;
    logic     squash;
  } ROB2MT;
endpackage

// File: rtl/map_table.sv
// map_table: register rename map with combinational lookup and CDB forwarding.
module map_table #(
  parameter int NUM_REGS = 32,
  parameter int ROB_LEN  = 8,
  localparam int TAG_W   = $clog2(ROB_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dp_valid,
  input  logic [4:0]       dp_dest_idx,
  input  logic [TAG_W-1:0] dp_rob_tag,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rs1_ready,
  output logic             rs2_ready,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             rt_valid,
  input  logic [4:0]       rt_dest_idx,
  input  logic [TAG_W-1:0] rt_rob_tag,
  input  logic             squash
);
  import map_table_pkg::*;
  logic [TAG_W-1:0] tag_q [NUM_REGS];
  logic [TAG_W-1:0] tag_d [NUM_REGS];
  logic             busy_q [NUM_REGS];
  logic             busy_d [NUM_REGS];
  logic             ready_q [NUM_REGS];
  logic             ready_d [NUM_REGS];
  // Lookups see the pre-dispatch state plus this cycle's completion broadcast.
  assign rs1_busy  = busy_q[rs1_idx];
  assign rs2_busy  = busy_q[rs2_idx];
  assign rs1_tag   = rs1_busy ? tag_q[rs1_idx] : '0;
  assign rs2_tag   = rs2_busy ? tag_q[rs2_idx] : '0;
  assign rs1_ready = rs1_busy & (ready_q[rs1_idx] | (cdb_valid & (tag_q[rs1_idx] == cdb_tag)));
  assign rs2_ready = rs2_busy & (ready_q[rs2_idx] | (cdb_valid & (tag_q[rs2_idx] == cdb_tag)));
  // Per-entry priority: squash, dispatch, matching retire, then CDB.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      tag_d[i]   = tag_q[i];
      busy_d[i]  = busy_q[i];
      ready_d[i] = ready_q[i];
      if (squash) begin
        tag_d[i]   = '0;
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end else if (dp_valid && dp_dest_idx == REG_LEN'(i) && i != ZERO_REG) begin
        tag_d[i]   = dp_rob_tag;
        busy_d[i]  = 1'b1;
        ready_d[i] = 1'b0;
      end else if (rt_valid && rt_dest_idx == REG_LEN'(i) && busy_q[i] && tag_q[i] == rt_rob_tag) begin
        tag_d[i]   = '0;
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end else if (cdb_valid && busy_q[i] && tag_q[i] == cdb_tag) begin
        ready_d[i] = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i]   <= '0;
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i]   <= tag_d[i];
        busy_q[i]  <= busy_d[i];
        ready_q[i] <= ready_d[i];
      end
    end
  end
endmodule

// File: tb/tb_map_table.sv
// tb_map_table: directed scoreboard bench for the rename map table.
module tb_map_table;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dp_valid = 1'b0, cdb_valid = 1'b0, rt_valid = 1'b0, squash = 1'b0;
  logic [4:0] dp_dest_idx = '0, rs1_idx = '0, rs2_idx = '0, rt_dest_idx = '0;
  logic [2:0] dp_rob_tag = '0, cdb_tag = '0, rt_rob_tag = '0;
  logic [2:0] rs1_tag, rs2_tag;
  logic       rs1_busy, rs2_busy, rs1_ready, rs2_ready;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string      name;
    bit         port;
    logic [4:0] exp;
  } exp_t;
  exp_t sb[$];
  map_table dut (
    .clock(clock), .reset(reset),
    .dp_valid(dp_valid), .dp_dest_idx(dp_dest_idx), .dp_rob_tag(dp_rob_tag),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .rt_valid(rt_valid), .rt_dest_idx(rt_dest_idx), .rt_rob_tag(rt_rob_tag),
    .squash(squash)
  );
  always #5 clock = ~clock;
  task automatic want(string n, bit p, logic b, logic r, logic [2:0] t);
    exp_t e;
    e.name = n;
    e.port = p;
    e.exp  = {b, r, t};
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [4:0] act;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.port ? {rs2_busy, rs2_ready, rs2_tag} : {rs1_busy, rs1_ready, rs1_tag};
      tests++;
      assert (act === e.exp) else begin
        fails++;
        $error("FAIL %s: got busy/ready/tag=%b required %b", e.name, act, e.exp);
      end
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    dp_valid = 1'b0;
    cdb_valid = 1'b0;
    rt_valid = 1'b0;
    squash = 1'b0;
  endtask
  task automatic dispatch(logic [4:0] r, logic [2:0] t);
    dp_valid = 1'b1;
    dp_dest_idx = r;
    dp_rob_tag = t;
  endtask
  initial begin
    rs1_idx = 5'd5;
    want("reset_r5", 0, 0, 0, 3'd0);
    check();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    dispatch(5'd5, 3'd3);
    want("pre_dispatch_hidden", 0, 0, 0, 3'd0);
    check();
    tick();
    want("dispatch_r5", 0, 1, 0, 3'd3);
    check();
    cdb_valid = 1'b1;
    cdb_tag = 3'd3;
    want("cdb_forward", 0, 1, 1, 3'd3);
    check();
    tick();
    want("cdb_persist", 0, 1, 1, 3'd3);
    check();
    dispatch(5'd7, 3'd1);
    tick();
    dispatch(5'd7, 3'd4);
    tick();
    rt_valid = 1'b1;
    rt_dest_idx = 5'd7;
    rt_rob_tag = 3'd1;
    rs2_idx = 5'd7;
    want("stale_retire_same", 1, 1, 0, 3'd4);
    check();
    tick();
    want("stale_retire_kept", 1, 1, 0, 3'd4);
    check();
    rt_valid = 1'b1;
    rt_dest_idx = 5'd5;
    rt_rob_tag = 3'd3;
    dispatch(5'd9, 3'd2);
    cdb_valid = 1'b1;
    cdb_tag = 3'd4;
    tick();
    rs1_idx = 5'd5;
    want("retire_r5", 0, 0, 0, 3'd0);
    rs2_idx = 5'd7;
    want("cdb_with_retire_r7", 1, 1, 1, 3'd4);
    check();
    rs1_idx = 5'd9;
    want("dispatch_with_retire_r9", 0, 1, 0, 3'd2);
    check();
    dispatch(5'd2, 3'd6);
    tick();
    dispatch(5'd2, 3'd0);
    cdb_valid = 1'b1;
    cdb_tag = 3'd6;
    rs1_idx = 5'd2;
    want("collision_fwd_old", 0, 1, 1, 3'd6);
    check();
    tick();
    want("collision_dispatch_wins", 0, 1, 0, 3'd0);
    check();
    dispatch(5'd1, 3'd1);
    tick();
    dispatch(5'd3, 3'd3);
    tick();
    rs1_idx = 5'd1;
    rs2_idx = 5'd3;
    want("pre_squash_r1", 0, 1, 0, 3'd1);
    want("pre_squash_r3", 1, 1, 0, 3'd3);
    check();
    squash = 1'b1;
    dispatch(5'd4, 3'd5);
    tick();
    want("squash_r1", 0, 0, 0, 3'd0);
    want("squash_r3", 1, 0, 0, 3'd0);
    check();
    rs1_idx = 5'd2;
    rs2_idx = 5'd4;
    want("squash_r2", 0, 0, 0, 3'd0);
    want("squash_r4_discarded", 1, 0, 0, 3'd0);
    check();
    dispatch(5'd0, 3'd7);
    tick();
    dispatch(5'd6, 3'd5);
    cdb_valid = 1'b1;
    cdb_tag = 3'd7;
    rs1_idx = 5'd0;
    want("r0_zero", 0, 0, 0, 3'd0);
    check();
    tick();
    dispatch(5'd8, 3'd6);
    tick();
    rs1_idx = 5'd6;
    rs2_idx = 5'd8;
    want("busy_r6", 0, 1, 0, 3'd5);
    want("busy_r8", 1, 1, 0, 3'd6);
    check();
    reset = 1'b1;
    want("async_reset_r6", 0, 0, 0, 3'd0);
    want("async_reset_r8", 1, 0, 0, 3'd0);
    check();
    tick();
    dispatch(5'd6, 3'd2);
    tick();
    want("reset_overrides_dispatch", 0, 0, 0, 3'd0);
    check();
    reset = 1'b0;
    dispatch(5'd6, 3'd2);
    tick();
    want("first_dispatch_after_reset", 0, 1, 0, 3'd2);
    check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: architectural register count; register 0 is the hardwired zero register.
REQ-002 SHALL have parameter ROB_LEN, default 8: ROB depth; TAG_W = $clog2(ROB_LEN).
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port dp_valid, input, 1: dispatch this cycle, already qualified upstream by stall and ROB structural hazard.
REQ-006 SHALL have port dp_dest_idx, input, 5: destination architectural register of the dispatching instruction.
REQ-007 SHALL have port dp_rob_tag, input, TAG_W: ROB tail index allocated to the dispatching instruction.
REQ-008 SHALL have ports rs1_idx and rs2_idx, input, 5 each: source register indices to look up.
REQ-009 SHALL have ports rs1_tag and rs2_tag, output, TAG_W each: ROB tag currently mapped to the source.
REQ-010 SHALL have ports rs1_busy and rs2_busy, output, 1 each: the source is renamed to an in-flight ROB entry.
REQ-011 SHALL have ports rs1_ready and rs2_ready, output, 1 each: the mapped ROB entry has completed, so its value is readable from the ROB.
REQ-012 SHALL have ports cdb_valid (input, 1) and cdb_tag (input, TAG_W): completion broadcast.
REQ-013 SHALL have ports rt_valid (input, 1), rt_dest_idx (input, 5) and rt_rob_tag (input, TAG_W): retirement of the ROB head.
REQ-014 SHALL have port squash, input, 1: mispredict flush from the ROB.

Function
REQ-015 SHALL hold one entry per register: tag (TAG_W bits), busy (1 bit) and ready (1 bit).
REQ-016 Lookups SHALL be purely combinational, with zero-cycle latency.
REQ-017 When an entry is not busy, its outputs SHALL be busy=0, ready=0, tag=0.
REQ-018 Lookup SHALL forward the same-cycle CDB: if the entry is busy and cdb_valid is high and the entry tag equals cdb_tag, the ready output SHALL be 1.
REQ-019 Lookup SHALL return the pre-dispatch mapping; a same-cycle dispatch to the same register SHALL NOT be visible until the next cycle.
REQ-020 On dispatch (dp_valid and dp_dest_idx != 0), the entry for dp_dest_idx SHALL be set next cycle to {tag=dp_rob_tag, busy=1, ready=0}.
REQ-021 On CDB (cdb_valid), every busy entry whose tag equals cdb_tag SHALL have ready set to 1.
REQ-022 On retire (rt_valid), the entry for rt_dest_idx SHALL have busy and ready cleared only if the entry is busy and its tag equals rt_rob_tag; otherwise the entry SHALL remain unchanged, because a newer mapping survives.
REQ-023 Register 0 SHALL never become busy; lookups of register 0 SHALL return busy=0, ready=0, tag=0.
REQ-024 Same-cycle conflict on one entry SHALL resolve by priority: squash first, then dispatch, then retire, then CDB.
- Dispatch overwrite leaves ready=0 even if the CDB matches the old tag.
REQ-025 Retire and CDB on different entries, or dispatch and retire on different entries, in the same cycle SHALL all take effect.
REQ-026 On squash, all entries SHALL become busy=0, ready=0, tag=0 next cycle, and a same-cycle dispatch SHALL be discarded.
REQ-027 ROB tags SHALL wrap modulo ROB_LEN; the table SHALL hold no ordering state beyond the tag.

Reset
REQ-028 Asserting reset SHALL immediately clear all entries (tag=0, busy=0, ready=0), so every lookup output reads 0 asynchronously.
REQ-029 Reset asserted mid-operation SHALL override all of dispatch, CDB, retire and squash.
REQ-030 The first dispatch SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 A shared package SHALL hold the MT_entry_PACKET typedef (tag, busy, ready), the RS2MT and MT2RS lookup packets, and ROB2MT, which carries head_idx, retire and squash.
- ZERO_REG, REG_LEN and ROB_LEN also come from the package.
REQ-032 SHALL be implemented as a single module with no sub-module, holding a flat array of NUM_REGS entries, next-state logic in combinational blocks and state in one flip-flop block.

Verification
REQ-033 Directed test, dispatch then lookup: dispatch r5 with tag 3, then look up rs1=r5 next cycle -> rs1_busy=1, rs1_tag=3, rs1_ready=0.
REQ-034 Directed test, CDB forwarding: r5 mapped to tag 3, cdb_valid with tag 3 while looking up r5 -> same cycle rs1_ready=1; next cycle ready=1 persists.
REQ-035 Directed test, stale retire: r7 mapped to tag 1, then remapped to tag 4, then retire of r7 with tag 1 -> r7 stays busy with tag 4.
REQ-036 Directed test, dispatch/CDB collision: r2 mapped to tag 6, then in one cycle dispatch r2 with tag 0 plus CDB tag 6 -> next cycle r2 tag=0, ready=0.
REQ-037 Directed test, squash: map r1, r2 and r3, then assert squash together with a dispatch of r4 -> next cycle all entries busy=0, including r4.
REQ-038 Directed test, r0 and reset: dispatch r0 -> lookup r0 returns 0; assert reset asynchronously mid-cycle with entries busy -> outputs 0 before the next edge.
